// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, memory-stage FSM encoding, LL/SC link granularity.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

    localparam int WORD_W   = 32;
    // Lowest address bit that takes part in the LL/SC link compare (word granularity).
    localparam int LINK_LSB = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } memstage_state_t;

endpackage

// File: rtl/llsc_link_reg.sv
// LL/SC link register: holds the linked word address and its valid bit, applies snoop/store kills.
// Latency: state updates on the CLK edge; checkHit is combinational.
// Backpressure: none; every strobe is consumed in the cycle it is presented.
//
// Ports: CLK/RST (sync, active-high); snoop_inv/snoop_addr coherence kill; llSet/stDone/scDone
// completion strobes from the memory stage with opAddr the address in flight; checkAddr/checkHit
// answers "would an SC to this address succeed right now".
module llsc_link_reg #(
    parameter int WORD_W   = cpu_types_pkg::WORD_W,
    parameter int LINK_LSB = cpu_types_pkg::LINK_LSB
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    input  logic              llSet,
    input  logic              stDone,
    input  logic              scDone,
    input  logic [WORD_W-1:0] opAddr,
    input  logic [WORD_W-1:0] checkAddr,
    output logic              checkHit
);

    logic              linkValid;
    logic [WORD_W-1:0] linkAddr;
    logic [WORD_W-1:0] tagAddr;
    logic              snoopKill;
    logic              storeKill;
    logic              snoopOnLink;

    // While an LL is completing, the address being linked is the one a snoop must hit to
    // stop the link from forming; otherwise compare against the held link.
    assign tagAddr   = llSet ? opAddr : linkAddr;
    assign snoopKill = snoop_inv && (snoop_addr[WORD_W-1:LINK_LSB] == tagAddr[WORD_W-1:LINK_LSB]);
    assign storeKill = stDone && (opAddr[WORD_W-1:LINK_LSB] == linkAddr[WORD_W-1:LINK_LSB]);

    // A snoop landing in the same cycle as the SC lookup already counts against it.
    assign snoopOnLink = snoop_inv && (snoop_addr[WORD_W-1:LINK_LSB] == linkAddr[WORD_W-1:LINK_LSB]);
    assign checkHit    = linkValid && !snoopOnLink &&
                         (checkAddr[WORD_W-1:LINK_LSB] == linkAddr[WORD_W-1:LINK_LSB]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            linkValid <= 1'b0;
            linkAddr  <= '0;
        end else if (snoopKill || storeKill) begin
            linkValid <= 1'b0;
        end else if (llSet) begin
            linkValid <= 1'b1;
            linkAddr  <= opAddr;
        end else if (scDone) begin
            linkValid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage_llsc.sv
// Memory-stage controller: drives the data-cache port from the EX/MEM latch, runs LL/SC, returns load/SC result.
// Latency: cache access = 1 + N + 1 cycles (N = ACCESS cycles up to dhit); failed SC = 2 cycles.
// Backpressure: mem_stall freezes the pipeline from request sight until dhit; drops for exactly one DONE cycle.
//
// Ports: CLK/RST (sync, active-high); ex_* latched request; dhit/dload cache response;
// snoop_inv/snoop_addr coherence invalidation; dREN/dWEN/daddr/dstore cache request;
// mem_stall pipeline freeze; load_out MEM/WB result; stat_stalls/stat_access counters.
// Optional counters are built only when MEMSTAGE_STATS_EN is defined; otherwise they read 0.
module mem_stage_llsc #(
    parameter int WORD_W   = cpu_types_pkg::WORD_W,
    parameter int LINK_LSB = cpu_types_pkg::LINK_LSB
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_ren,
    input  logic              ex_wen,
    input  logic              ex_atomic,
    input  logic [WORD_W-1:0] ex_addr,
    input  logic [WORD_W-1:0] ex_store,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] load_out,
    output logic [31:0]       stat_stalls,
    output logic [31:0]       stat_access
);
    import cpu_types_pkg::*;

    memstage_state_t state;
    logic            accAtomic;
    logic            anyReq;
    logic            isSc;
    logic            scLinkHit;
    logic            startAccess;
    logic            scMiss;
    logic            accDone;
    logic            llSet;
    logic            stDone;
    logic            scDone;

    // Read wins when ren and wen are both set, so an SC is strictly wen+atomic without ren.
    assign anyReq      = ex_ren || ex_wen;
    assign isSc        = ex_wen && ex_atomic && !ex_ren;
    assign startAccess = (state == IDLE) && anyReq && (!isSc || scLinkHit);
    assign scMiss      = (state == IDLE) && isSc && !scLinkHit;
    assign accDone     = (state == ACCESS) && dhit;
    assign llSet       = accDone && dREN && accAtomic;
    assign stDone      = accDone && dWEN && !accAtomic;
    assign scDone      = scMiss || (accDone && dWEN && accAtomic);

    assign mem_stall = !RST && (((state == IDLE) && anyReq) || (state == ACCESS));

    llsc_link_reg #(
        .WORD_W   (WORD_W),
        .LINK_LSB (LINK_LSB)
    ) uLink (
        .CLK        (CLK),
        .RST        (RST),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr),
        .llSet      (llSet),
        .stDone     (stDone),
        .scDone     (scDone),
        .opAddr     (daddr),
        .checkAddr  (ex_addr),
        .checkHit   (scLinkHit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            dREN      <= 1'b0;
            dWEN      <= 1'b0;
            daddr     <= '0;
            dstore    <= '0;
            load_out  <= '0;
            accAtomic <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startAccess) begin
                        state     <= ACCESS;
                        dREN      <= ex_ren;
                        dWEN      <= ex_wen && !ex_ren;
                        daddr     <= ex_addr;
                        dstore    <= ex_store;
                        accAtomic <= ex_atomic;
                    end else if (scMiss) begin
                        state    <= DONE;
                        load_out <= '0;
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        state <= DONE;
                        dREN  <= 1'b0;
                        dWEN  <= 1'b0;
                        if (dREN) begin
                            load_out <= dload;
                        end else if (accAtomic) begin
                            load_out <= {{(WORD_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEMSTAGE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_stalls <= '0;
            stat_access <= '0;
        end else begin
            if (mem_stall) stat_stalls <= stat_stalls + 32'd1;
            if (accDone)   stat_access <= stat_access + 32'd1;
        end
    end
`else
    assign stat_stalls = '0;
    assign stat_access = '0;
`endif

endmodule
